// File: rtl/mem_prog_loader_if.sv
// Byte-stream and memory-write bundle between an image source/instruction memory and the loader.
// Latency: none (wires only).
// Backpressure: byte_ready from the loader stalls the source; the write port has no backpressure.
//
// Signals:
//   byte_valid / byte_data[7:0] / byte_last : byte stream, source -> loader
//   byte_ready                              : loader -> source, byte consumed when valid && ready
//   waddress[31:0] / wdata[31:0] / wr       : memory write port, loader -> memory
// Modports:
//   master : stream source / memory side
//   slave  : loader side
interface mem_prog_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_last;
    logic        byte_ready;
    logic [31:0] waddress;
    logic [31:0] wdata;
    logic        wr;

    modport master (
        output byte_valid,
        output byte_data,
        output byte_last,
        input  byte_ready,
        input  waddress,
        input  wdata,
        input  wr
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        input  byte_last,
        output byte_ready,
        output waddress,
        output wdata,
        output wr
    );
endinterface

// File: rtl/mem_prog_loader.sv
// Packs a little-endian byte stream into 32-bit words and writes them to instruction memory.
// Latency: the byte completing a word is accepted at edge N; wr is high during cycle N+1.
// Backpressure: byte_ready is low outside COLLECT (one WRITE cycle per word -> 4 bytes per 5 cycles).
//
// Ports:
//   clk, reset  : single rising-edge clock, synchronous active-high reset
//   start       : one-cycle pulse, begins a load from IDLE, DONE or ERROR; ignored while busy
//   ld          : byte stream in, memory write port out (mem_prog_loader_if.slave)
//   word_count  : words written since the last start
//   busy        : load in progress (COLLECT or WRITE)
//   done        : complete image written
//   error       : image exceeded MAX_WORDS words
//   cpu_hold    : holds the CPU in reset; low only once an image is fully loaded
module mem_prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          MAX_WORDS = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    mem_prog_loader_if.slave   ld,
    output logic [15:0]        word_count,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               cpu_hold
);

    localparam logic [15:0] MAX_W = MAX_WORDS[15:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state;
    state_t      state_n;

    logic [1:0]  idx;
    logic [1:0]  idx_n;
    logic        last_seen;
    logic        last_seen_n;
    logic [31:0] waddr_q;
    logic [31:0] waddr_n;
    logic [31:0] wdata_q;
    logic [31:0] wdata_n;
    logic [15:0] wcnt_q;
    logic [15:0] wcnt_n;

    logic        byte_ready_c;
    logic        wr_c;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath registers. Reset discards any partially packed word, so an
    // aborted load never produces a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= 2'd0;
            last_seen <= 1'b0;
            waddr_q   <= BASE_ADDR;
            wdata_q   <= 32'h0;
            wcnt_q    <= 16'h0;
        end else begin
            idx       <= idx_n;
            last_seen <= last_seen_n;
            waddr_q   <= waddr_n;
            wdata_q   <= wdata_n;
            wcnt_q    <= wcnt_n;
        end
    end

    // Next-state, next-datapath and handshake outputs.
    always_comb begin
        state_n      = state;
        idx_n        = idx;
        last_seen_n  = last_seen;
        waddr_n      = waddr_q;
        wdata_n      = wdata_q;
        wcnt_n       = wcnt_q;
        byte_ready_c = 1'b0;
        wr_c         = 1'b0;

        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_n     = S_COLLECT;
                    idx_n       = 2'd0;
                    last_seen_n = 1'b0;
                    waddr_n     = BASE_ADDR;
                    wcnt_n      = 16'h0;
                end
            end

            S_COLLECT: begin
                byte_ready_c = 1'b1;
                if (ld.byte_valid) begin
                    // The first byte of a word zeroes the upper lanes so a
                    // short final word is written with zero padding.
                    if (idx == 2'd0) begin
                        wdata_n = {24'h0, ld.byte_data};
                    end else begin
                        wdata_n[{idx, 3'b000} +: 8] = ld.byte_data;
                    end

                    if (idx == 2'd3 || ld.byte_last) begin
                        state_n     = S_WRITE;
                        last_seen_n = ld.byte_last;
                    end else begin
                        idx_n = idx + 2'd1;
                    end
                end
            end

            S_WRITE: begin
                wr_c    = 1'b1;
                waddr_n = waddr_q + 32'd4;
                wcnt_n  = wcnt_q + 16'd1;
                idx_n   = 2'd0;
                // A completed image wins over the capacity check: an image of
                // exactly MAX_WORDS words ends in DONE.
                if (last_seen) begin
                    state_n = S_DONE;
                end else if (wcnt_n == MAX_W) begin
                    state_n = S_ERROR;
                end else begin
                    state_n = S_COLLECT;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign ld.byte_ready = byte_ready_c;
    assign ld.wr         = wr_c;
    assign ld.waddress   = waddr_q;
    assign ld.wdata      = wdata_q;

    assign word_count = wcnt_q;
    assign busy       = (state == S_COLLECT) || (state == S_WRITE);
    assign done       = (state == S_DONE);
    assign error      = (state == S_ERROR);
    assign cpu_hold   = (state != S_DONE);

endmodule

// File: tb/tb_mem_prog_loader.sv
// Bench for mem_prog_loader: two instances (default parameters, and BASE_ADDR=0x100/MAX_WORDS=2)
// driven with directed and random byte images; expected writes and final status come from
// packing the image bytes directly.
module tb_mem_prog_loader;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start [2];

    logic        bv [2];
    logic        bl [2];
    logic [7:0]  bd [2];
    logic        br [2];
    logic        wr [2];
    logic [31:0] wa [2];
    logic [31:0] wd [2];
    logic [15:0] wc [2];
    logic        busy [2];
    logic        done [2];
    logic        err [2];
    logic        hold [2];

    mem_prog_loader_if ifa ();
    mem_prog_loader_if ifb ();

    assign ifa.byte_valid = bv[0];
    assign ifa.byte_data  = bd[0];
    assign ifa.byte_last  = bl[0];
    assign br[0] = ifa.byte_ready;
    assign wr[0] = ifa.wr;
    assign wa[0] = ifa.waddress;
    assign wd[0] = ifa.wdata;

    assign ifb.byte_valid = bv[1];
    assign ifb.byte_data  = bd[1];
    assign ifb.byte_last  = bl[1];
    assign br[1] = ifb.byte_ready;
    assign wr[1] = ifb.wr;
    assign wa[1] = ifb.waddress;
    assign wd[1] = ifb.wdata;

    mem_prog_loader u_a (
        .clk        (clk),
        .reset      (reset),
        .start      (start[0]),
        .ld         (ifa),
        .word_count (wc[0]),
        .busy       (busy[0]),
        .done       (done[0]),
        .error      (err[0]),
        .cpu_hold   (hold[0])
    );

    mem_prog_loader #(.BASE_ADDR(32'h100), .MAX_WORDS(2)) u_b (
        .clk        (clk),
        .reset      (reset),
        .start      (start[1]),
        .ld         (ifb),
        .word_count (wc[1]),
        .busy       (busy[1]),
        .done       (done[1]),
        .error      (err[1]),
        .cpu_hold   (hold[1])
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] base_of(input int d);
        return (d == 0) ? 32'h0 : 32'h100;
    endfunction

    function automatic int max_of(input int d);
        return (d == 0) ? 64 : 2;
    endfunction

    // Write monitor: every wr cycle is recorded; the stream must be stalled then.
    logic [63:0] wq_a[$];
    logic [63:0] wq_b[$];

    always @(negedge clk) begin
        if (wr[0] === 1'b1) begin
            wq_a.push_back({wa[0], wd[0]});
            chk("ready_during_wr_a", 64'(br[0]), 64'd0);
        end
        if (wr[1] === 1'b1) begin
            wq_b.push_back({wa[1], wd[1]});
            chk("ready_during_wr_b", 64'(br[1]), 64'd0);
        end
    end

    task automatic check_reset(input int d);
        chk("rst_ready", 64'(br[d]),   64'd0);
        chk("rst_wr",    64'(wr[d]),   64'd0);
        chk("rst_addr",  64'(wa[d]),   64'(base_of(d)));
        chk("rst_wdata", 64'(wd[d]),   64'd0);
        chk("rst_count", 64'(wc[d]),   64'd0);
        chk("rst_busy",  64'(busy[d]), 64'd0);
        chk("rst_done",  64'(done[d]), 64'd0);
        chk("rst_error", 64'(err[d]),  64'd0);
        chk("rst_hold",  64'(hold[d]), 64'd1);
    endtask

    // Presents one byte after 'gap' idle cycles, holds it until accepted, then
    // checks whether a write strobe follows in the next cycle. Starts and ends
    // on a falling edge.
    task automatic send_byte(input int d, input logic [7:0] data, input bit last,
                             input int gap, input bit completes, output bit ok);
        int t;
        ok = 1'b1;
        if (gap > 0) begin
            bv[d] = 1'b0;
            repeat (gap) @(negedge clk);
        end
        bv[d] = 1'b1;
        bd[d] = data;
        bl[d] = last;
        t = 0;
        while (br[d] !== 1'b1 && t < 32) begin
            @(negedge clk);
            t++;
        end
        if (br[d] !== 1'b1) begin
            chk("accept_timeout", 64'd0, 64'd1);
            ok = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        chk("wr_latency", 64'(wr[d]), 64'(completes));
    endtask

    // Full load of one image. Without byte_last the image must exceed capacity.
    task automatic run_load(input int d, input bq_t img, input bit with_last,
                            input int gap_max, input bit poke_start);
        int          n, nw, mx, nsend, nwr, t;
        logic [31:0] base, w;
        bit          exp_err, ok, lastb;
        logic [63:0] got[$];

        n       = img.size();
        nw      = (n + 3) / 4;
        mx      = max_of(d);
        base    = base_of(d);
        exp_err = with_last ? (nw > mx) : 1'b1;
        nsend   = exp_err ? 4 * mx : n;
        nwr     = exp_err ? mx : nw;

        if (d == 0) wq_a.delete(); else wq_b.delete();

        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        chk("start_busy",  64'(busy[d]), 64'd1);
        chk("start_count", 64'(wc[d]),   64'd0);
        chk("start_hold",  64'(hold[d]), 64'd1);
        chk("start_addr",  64'(wa[d]),   64'(base));

        for (int i = 0; i < nsend; i++) begin
            if (poke_start && i == nsend / 2) start[d] = 1'b1;
            lastb = with_last && (i == n - 1);
            send_byte(d, img[i], lastb, int'($urandom_range(0, gap_max)),
                      (i % 4 == 3) || lastb, ok);
            start[d] = 1'b0;
            if (!ok) break;
        end
        bv[d] = 1'b0;
        bl[d] = 1'b0;

        t = 0;
        while (!(done[d] || err[d]) && t < 16) begin
            @(negedge clk);
            t++;
        end
        chk("end_done_err", {62'd0, done[d], err[d]}, exp_err ? 64'd1 : 64'd2);

        if (exp_err) begin
            // Surplus byte must stay unconsumed and produce no further write.
            bv[d] = 1'b1;
            bd[d] = 8'($urandom_range(0, 255));
            repeat (4) @(negedge clk);
            chk("err_ready", 64'(br[d]), 64'd0);
            bv[d] = 1'b0;
        end

        chk("end_hold",  64'(hold[d]), 64'(exp_err));
        chk("end_busy",  64'(busy[d]), 64'd0);
        chk("end_count", 64'(wc[d]),   64'(nwr));

        if (d == 0) got = wq_a; else got = wq_b;
        chk("wr_total", 64'(got.size()), 64'(nwr));
        for (int k = 0; k < nwr; k++) begin
            w = 32'h0;
            for (int j = 0; j < 4; j++) begin
                if (4 * k + j < n) w = w | ({24'h0, img[4 * k + j]} << (8 * j));
            end
            if (k < got.size()) chk("wr_word", got[k], {base + 32'(4 * k), w});
        end
    endtask

    function automatic bq_t ramp(input int n);
        bq_t q;
        for (int i = 1; i <= n; i++) q.push_back(8'(i));
        return q;
    endfunction

    function automatic bq_t rand_img(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    initial begin
        bq_t img;
        bit  ok;

        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0;
            bv[d]    = 1'b0;
            bl[d]    = 1'b0;
            bd[d]    = 8'h0;
        end
        repeat (3) @(negedge clk);
        check_reset(0);
        check_reset(1);
        reset = 1'b0;
        @(negedge clk);

        // Normal load, valid held high through WRITE cycles.
        run_load(0, ramp(8), 1'b1, 0, 1'b0);

        // Partial final word.
        img = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        run_load(0, img, 1'b1, 0, 1'b0);

        // Random source gaps plus a start pulse while busy.
        run_load(0, ramp(8), 1'b1, 3, 1'b1);

        // Overflow on the two-word instance.
        run_load(1, ramp(9), 1'b0, 1, 1'b0);

        // Reset after two accepted bytes.
        wq_a.delete();
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        send_byte(0, 8'h11, 1'b0, 0, 1'b0, ok);
        send_byte(0, 8'h22, 1'b0, 0, 1'b0, ok);
        bv[0] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check_reset(0);
        check_reset(1);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_no_wr", 64'(wq_a.size()), 64'd0);
        run_load(0, ramp(8), 1'b1, 1, 1'b0);

        // Restart from DONE at BASE_ADDR 0x100.
        run_load(1, ramp(5), 1'b1, 1, 1'b0);
        run_load(1, rand_img(7), 1'b1, 2, 1'b0);

        // Random images.
        for (int r = 0; r < 10; r++) begin
            run_load(0, rand_img(int'($urandom_range(1, 24))), 1'b1, 3, r[0]);
        end
        for (int r = 0; r < 8; r++) begin
            run_load(1, rand_img(int'($urandom_range(1, 12))), 1'b1, 2, 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
